// File: rtl/donut_pkg.sv
// Shared constants, Bayer table and pipeline record types for the donut pixel output stage.
package donut_pkg;

    localparam int H_DISPLAY_DEF = 1220;
    localparam int V_DISPLAY_DEF = 480;

    // Full-brightness fade level; L_eff = L when fade reaches this.
    localparam logic [4:0] FADE_MAX = 5'd16;

    // 4x4 ordered-dither thresholds, indexed [y][x].
    localparam logic [3:0] BAYER [0:3][0:3] = '{
        '{4'd0,  4'd8,  4'd2,  4'd10},
        '{4'd12, 4'd4,  4'd14, 4'd6 },
        '{4'd3,  4'd11, 4'd1,  4'd9 },
        '{4'd15, 4'd7,  4'd13, 4'd5 }
    };

    typedef enum logic {
        FADE_IN = 1'b0,
        RUN     = 1'b1
    } fade_state_e;

    typedef struct packed {
        logic       active;
        logic       vis;
        logic [5:0] luma;
        logic [3:0] t;
        logic       hs;
        logic       vs;
    } s1_t;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
        logic       hs;
        logic       vs;
    } pix_t;

endpackage

// File: rtl/donut_pixel_out_if.sv
// Pixel-stage bus: timing counters and renderer result in, VGA pins and frame parity out.
interface donut_pixel_out_if;
    logic [10:0] h_count;
    logic [9:0]  v_count;
    logic        hsync_in;
    logic        vsync_in;
    logic        donut_visible;
    logic [5:0]  donut_luma;
    logic        frame;
    logic [1:0]  r;
    logic [1:0]  g;
    logic [1:0]  b;
    logic        hsync;
    logic        vsync;

    modport master (
        output h_count, v_count, hsync_in, vsync_in, donut_visible, donut_luma,
        input  frame, r, g, b, hsync, vsync
    );

    modport slave (
        input  h_count, v_count, hsync_in, vsync_in, donut_visible, donut_luma,
        output frame, r, g, b, hsync, vsync
    );
endinterface

// File: rtl/donut_pixel_out_bayer4x4.sv
// Combinational 4x4 Bayer threshold lookup.
module bayer4x4
    import donut_pkg::*;
(
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic [3:0] t
);
    assign t = BAYER[y][x];
endmodule

// File: rtl/donut_pixel_out.sv
// Donut pixel output stage: 2-clock dither/fade/blank pipeline plus power-on fade FSM.
// Optional macro DONUT_TEMPORAL_DITHER_EN inverts the dither threshold on odd frames.
module donut_pixel_out
    import donut_pkg::*;
#(
    parameter int H_DISPLAY      = H_DISPLAY_DEF,
    parameter int V_DISPLAY      = V_DISPLAY_DEF,
    parameter int DITHER_SHIFT   = 3,
    parameter int FADE_STEP_LOG2 = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    donut_pixel_out_if.slave px
);

    localparam int SUB_W = (FADE_STEP_LOG2 > 0) ? FADE_STEP_LOG2 : 1;
    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'((1 << FADE_STEP_LOG2) - 1);

    localparam s1_t  S1_RST  = '{active: 1'b0, vis: 1'b0, luma: 6'd0, t: 4'd0, hs: 1'b1, vs: 1'b1};
    localparam pix_t PIX_RST = '{r: 2'd0, g: 2'd0, b: 2'd0, hs: 1'b1, vs: 1'b1};

    fade_state_e      state_q;
    logic [4:0]       fade_q;
    logic [SUB_W-1:0] sub_q;
    logic             frame_q;
    logic             frame_evt;

    s1_t        s1_d, s1_q;
    pix_t       pix_d, pix_q;
    logic [3:0] t_raw;
    logic [6:0] l_eff;
    logic [1:0] q;

    assign frame_evt = (px.h_count == 11'd0) && (px.v_count == 10'(V_DISPLAY));

    // Fade FSM: every 2^FADE_STEP_LOG2 frame events raise fade by one until full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FADE_IN;
            fade_q  <= 5'd0;
            sub_q   <= '0;
            frame_q <= 1'b0;
        end else if (frame_evt) begin
            frame_q <= ~frame_q;
            if (state_q == FADE_IN) begin
                if (sub_q == SUB_MAX) begin
                    sub_q  <= '0;
                    fade_q <= fade_q + 5'd1;
                    if (fade_q == FADE_MAX - 5'd1) state_q <= RUN;
                end else begin
                    sub_q <= sub_q + 1'b1;
                end
            end
        end
    end

    bayer4x4 u_bayer (
        .x (px.h_count[DITHER_SHIFT+1:DITHER_SHIFT]),
        .y (px.v_count[1:0]),
        .t (t_raw)
    );

    always_comb begin
        s1_d        = S1_RST;
        s1_d.active = (px.h_count < 11'(H_DISPLAY)) && (px.v_count < 10'(V_DISPLAY));
        s1_d.vis    = px.donut_visible;
        s1_d.luma   = px.donut_luma;
        s1_d.hs     = px.hsync_in;
        s1_d.vs     = px.vsync_in;
`ifdef DONUT_TEMPORAL_DITHER_EN
        s1_d.t      = frame_q ? ~t_raw : t_raw;   // 15-T on odd frames
`else
        s1_d.t      = t_raw;
`endif
    end

    // sum = 3*L_eff + 4*T + 2 peaks at 251, so 8 bits never overflow.
    always_comb begin
        l_eff = 7'(({5'b0, s1_q.luma} * {6'b0, fade_q}) >> 4);
        q     = 2'(({1'b0, l_eff} * 8'd3 + {2'b0, s1_q.t, 2'b0} + 8'd2) >> 6);

        pix_d    = PIX_RST;
        pix_d.hs = s1_q.hs;
        pix_d.vs = s1_q.vs;
        if (s1_q.active) begin
            if (s1_q.vis) begin
                pix_d.r = q;
                pix_d.g = q;
                pix_d.b = q;
            end else begin
                pix_d.b = 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= S1_RST;
            pix_q <= PIX_RST;
        end else begin
            s1_q  <= s1_d;
            pix_q <= pix_d;
        end
    end

    assign px.frame = frame_q;
    assign px.r     = pix_q.r;
    assign px.g     = pix_q.g;
    assign px.b     = pix_q.b;
    assign px.hsync = pix_q.hs;
    assign px.vsync = pix_q.vs;

endmodule
